// File: rtl/ov7670_config_sequencer.sv
// OV7670 register-init sequencer: walks the init ROM and issues SCCB writes.
// Ports: clk/rst_n, start, rom_addr/rom_dout, cmd_* handshake, busy/done/write_count.
module ov7670_config_sequencer #(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int DELAY_MS     = 10,
  parameter int MIN_END_ADDR = 38
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_dout,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_reg,
  output logic [7:0]  cmd_data,
  input  logic        cmd_done,
  output logic        busy,
  output logic        done,
  output logic [7:0]  write_count
);

  localparam int DELAY_CYCLES = CLK_FREQ / 1000 * DELAY_MS;
  localparam logic [31:0] DLY_LAST =
    (DELAY_CYCLES > 0) ? 32'(DELAY_CYCLES - 1) : 32'd0;
  localparam logic [8:0] END_ADDR = 9'(MIN_END_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_WAIT_DONE,
    S_DELAY,
    S_FINISH
  } state_t;

  state_t      state;
  logic [31:0] dly_cnt;

  logic end_word;
  logic dly_word;
  logic at_end;
  logic last_addr;

  assign end_word  = (rom_dout == 16'hFFFF);
  assign dly_word  = (rom_dout == 16'hFFF0);
  assign at_end    = ({1'b0, rom_addr} >= END_ADDR);
  assign last_addr = (rom_addr == 8'hFF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rom_addr    <= 8'd0;
      cmd_valid   <= 1'b0;
      cmd_reg     <= 8'd0;
      cmd_data    <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      write_count <= 8'd0;
      dly_cnt     <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_FETCH;
            rom_addr    <= 8'd0;
            done        <= 1'b0;
            write_count <= 8'd0;
            busy        <= 1'b1;
          end
        end
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (end_word && at_end) begin
            state <= S_FINISH;
            done  <= 1'b1;
          end else if (end_word) begin
            // hole in the table: skip without a command
            if (last_addr) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              rom_addr <= rom_addr + 8'd1;
              state    <= S_FETCH;
            end
          end else if (dly_word) begin
            state   <= S_DELAY;
            dly_cnt <= 32'd0;
          end else begin
            state     <= S_SEND;
            cmd_valid <= 1'b1;
            cmd_reg   <= rom_dout[15:8];
            cmd_data  <= rom_dout[7:0];
          end
        end
        S_SEND: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (cmd_done) begin
            if (write_count != 8'hFF)
              write_count <= write_count + 8'd1;
            if (last_addr) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              rom_addr <= rom_addr + 8'd1;
              state    <= S_FETCH;
            end
          end
        end
        S_DELAY: begin
          dly_cnt <= dly_cnt + 32'd1;
          if (dly_cnt == DLY_LAST) begin
            if (last_addr) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              rom_addr <= rom_addr + 8'd1;
              state    <= S_FETCH;
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: ROM + SCCB models, vector table
// of full runs, plus hand sequences for delay timing, restart and reset.
module tb_ov7670_config_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_reg;
  logic [7:0]  cmd_data;
  logic        cmd_done;
  logic        busy;
  logic        done;
  logic [7:0]  write_count;

  ov7670_config_sequencer #(
    .CLK_FREQ(1000),
    .DELAY_MS(5),
    .MIN_END_ADDR(38)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .rom_addr(rom_addr),
    .rom_dout(rom_dout),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_reg(cmd_reg),
    .cmd_data(cmd_data),
    .cmd_done(cmd_done),
    .busy(busy),
    .done(done),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  logic        ready_en;
  int          dcnt = 0;
  int          cyc = 0;
  logic        pv = 1'b0;
  logic [15:0] wr_q [$];
  int          rise_q [$];
  int          done_q [$];
  int          errors = 0;
  int          checks = 0;

  assign cmd_ready = ready_en;

  always @(posedge clk) rom_dout <= rom[rom_addr];

  // SCCB master model: done pulse 5 clocks after accept
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin
      wr_q.push_back({cmd_reg, cmd_data});
      dcnt <= 5;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end
    cmd_done <= (dcnt == 1);
  end

  always @(negedge clk) begin
    if (cmd_done) done_q.push_back(cyc);
    if (cmd_valid && !pv) rise_q.push_back(cyc);
    pv <= cmd_valid;
  end

  typedef struct {
    int          pat;
    int          stall;
    int          nwr;
    logic [7:0]  wc;
    logic [15:0] first;
    logic [15:0] last;
    logic [7:0]  addr;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] qget(int i);
    if (i >= 0 && i < wr_q.size()) return wr_q[i];
    return 16'hDEAD;
  endfunction

  task automatic load(int pat);
    for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
    case (pat)
      0: begin
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1210;
        rom[3] = 16'hFFFF;
        rom[4] = 16'h0C04;
      end
      1: rom[0] = 16'h3344;
      2: for (int a = 0; a < 256; a++) rom[a] = 16'h3300;
      default: rom[38] = 16'h5566;
    endcase
  endtask

  task automatic clr();
    wr_q.delete();
    rise_q.delete();
    done_q.delete();
  endtask

  task automatic wait_end(string nm);
    int n = 0;
    while (!(done && !busy) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_end"}, {31'd0, done && !busy}, 32'd1);
  endtask

  task automatic run_seq(int stall, string nm);
    int n = 0;
    logic [7:0] r;
    logic [7:0] d;
    bit stable = 1'b1;
    clr();
    ready_en = (stall == 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (stall > 0) begin
      while (!cmd_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk({nm, "_bp_valid"}, {31'd0, cmd_valid}, 32'd1);
      r = cmd_reg;
      d = cmd_data;
      repeat (stall) begin
        @(negedge clk);
        if (!cmd_valid || cmd_reg != r || cmd_data != d)
          stable = 1'b0;
      end
      chk({nm, "_bp_stable"}, {31'd0, stable}, 32'd1);
      ready_en = 1'b1;
    end
    wait_end(nm);
  endtask

  task automatic do_reset_chk(string nm);
    rst_n = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, {31'd0, cmd_valid}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, done}, 32'd0);
    chk({nm, "_addr"}, {24'd0, rom_addr}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    tbl[0] = '{0, 0, 3,   8'd3,   16'h1280, 16'h0C04, 8'd38};
    tbl[1] = '{1, 7, 1,   8'd1,   16'h3344, 16'h3344, 8'd38};
    tbl[2] = '{2, 0, 256, 8'd255, 16'h3300, 16'h3300, 8'd255};
    tbl[3] = '{3, 0, 1,   8'd1,   16'h5566, 16'h5566, 8'd39};

    rst_n = 1'b0;
    start = 1'b0;
    ready_en = 1'b1;
    load(0);
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wc", {24'd0, write_count}, 32'd0);
    chk("rst_addr", {24'd0, rom_addr}, 32'd0);
    chk("rst_reg", {24'd0, cmd_reg}, 32'd0);
    chk("rst_data", {24'd0, cmd_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      load(tbl[i].pat);
      run_seq(tbl[i].stall, $sformatf("v%0d", i));
      chk($sformatf("v%0d_nwr", i), wr_q.size(), tbl[i].nwr);
      chk($sformatf("v%0d_wc", i), {24'd0, write_count}, {24'd0, tbl[i].wc});
      chk($sformatf("v%0d_first", i), {16'd0, qget(0)}, {16'd0, tbl[i].first});
      chk($sformatf("v%0d_last", i), {16'd0, qget(wr_q.size() - 1)},
          {16'd0, tbl[i].last});
      chk($sformatf("v%0d_addr", i), {24'd0, rom_addr}, {24'd0, tbl[i].addr});
      repeat (10) @(negedge clk);
      chk($sformatf("v%0d_idle", i), {30'd0, busy, done}, 32'd1);
    end

    // write order and delay/hole timing (done seen -> next valid rise)
    load(0);
    run_seq(0, "dly");
    chk("dly_mid", {16'd0, qget(1)}, 32'h1210);
    if (rise_q.size() == 3 && done_q.size() == 3) begin
      chk("dly_gap", rise_q[1] - done_q[0], 10);
      chk("hole_gap", rise_q[2] - done_q[1], 5);
    end else begin
      chk("dly_events", rise_q.size() * 10 + done_q.size(), 33);
    end

    // start mid-run and during FINISH is ignored
    clr();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (wr_q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(done && busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("fin_seen", {31'd0, done && busy}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("norestart_busy", {31'd0, busy}, 32'd0);
    chk("norestart_nwr", wr_q.size(), 3);

    // rerun from done=1 clears the count
    clr();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rerun_wc0", {24'd0, write_count}, 32'd0);
    chk("rerun_flags", {30'd0, busy, done}, 32'd2);
    wait_end("rerun");
    chk("rerun_wc", {24'd0, write_count}, 32'd3);

    // reset while holding a command in SEND
    clr();
    ready_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!cmd_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_valid", {31'd0, cmd_valid}, 32'd1);
    do_reset_chk("rsend");
    ready_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("rsend_nwr", wr_q.size(), 0);

    // reset while in DELAY
    clr();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done_q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("dly_novalid", {31'd0, cmd_valid}, 32'd0);
    do_reset_chk("rdly");
    repeat (30) @(negedge clk);
    chk("rdly_nwr", wr_q.size(), 1);
    chk("rdly_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
